fp_operand_sequencer: RTL and testbench

//  Upstream stimulus stage for the pipelined FP adder on the board.
//  - Debounces the push-button input.
//  - On each clean press, steps through an 8-entry ROM of operand pairs and drives reg_A/reg_B into the adder.
//  - Waits out the adder pipeline latency, then captures the adder output into a hold register for the LED/7-seg drivers.

---
 rtl/fp_operand_sequencer.sv | 151 +++++++++++++++
 tb/tb_fp_operand_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_sequencer.sv
// Push-button driven operand stepper for the pipelined FP adder: debounces the
// button, loads the next ROM operand pair and captures the adder result later.
module fp_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_VECTORS     = 8,
  parameter int PIPE_LATENCY    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           noisy_level,
  input  logic [31:0]                    fp_result,
  output logic [31:0]                    reg_A,
  output logic [31:0]                    reg_B,
  output logic [$clog2(NUM_VECTORS)-1:0] vec_index,
  output logic                           busy,
  output logic                           result_valid,
  output logic [31:0]                    result_hold
);

  localparam int IDX_W = $clog2(NUM_VECTORS);
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LAT_W = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PIPE_LATENCY);

  typedef enum logic {IDLE, WAIT} state_t;

  // Operand pairs packed as {A, B}.
  function automatic logic [63:0] rom_entry(input logic [IDX_W-1:0] idx);
    logic [63:0] word;
    case (int'(idx))
      0:       word = {32'h2ac49214, 32'h6ac49214};
      1:       word = {32'h3f800000, 32'h3f800000};
      2:       word = {32'h40400000, 32'hc0400000};
      3:       word = {32'h7f800000, 32'h3f800000};
      4:       word = {32'h3fc00000, 32'h3fc00000};
      5:       word = {32'h00000000, 32'h00000000};
      6:       word = {32'h7f7fffff, 32'h7f7fffff};
      7:       word = {32'hc0000000, 32'h3f800000};
      default: word = 64'h0;
    endcase
    return word;
  endfunction

  logic             sync_meta_reg;
  logic             sync_reg;
  logic             stable_reg;
  logic             stable_d_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      stable_reg    <= 1'b0;
      stable_d_reg  <= 1'b0;
      deb_cnt_reg   <= '0;
    end else begin
      sync_meta_reg <= noisy_level;
      sync_reg      <= sync_meta_reg;
      stable_d_reg  <= stable_reg;
      if (sync_reg == stable_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        stable_reg  <= sync_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  // Only the accepted 0->1 transition of the debounced level is an event.
  assign press = stable_reg & ~stable_d_reg;

  state_t           state_reg,  state_next;
  logic [IDX_W-1:0] idx_reg,    idx_next;
  logic [31:0]      op_a_reg,   op_a_next;
  logic [31:0]      op_b_reg,   op_b_next;
  logic [LAT_W-1:0] lat_reg,    lat_next;
  logic             busy_reg,   busy_next;
  logic             valid_reg,  valid_next;
  logic [31:0]      hold_reg,   hold_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg              <= IDLE;
      idx_reg                <= '0;
      {op_a_reg, op_b_reg}   <= rom_entry('0);
      lat_reg                <= '0;
      busy_reg               <= 1'b0;
      valid_reg              <= 1'b0;
      hold_reg               <= 32'h0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
      lat_reg   <= lat_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
    lat_next   = lat_reg;
    busy_next  = busy_reg;
    valid_next = valid_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (press) begin
          idx_next               = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
          {op_a_next, op_b_next} = rom_entry(idx_next);
          valid_next             = 1'b0;
          busy_next              = 1'b1;
          lat_next               = LAT_INIT;
          state_next             = WAIT;
        end
      end
      WAIT: begin
        // Presses arriving here are dropped; capture one edge after the count expires.
        if (lat_reg != '0) begin
          lat_next = lat_reg - 1'b1;
        end else begin
          hold_next  = fp_result;
          valid_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign reg_A        = op_a_reg;
  assign reg_B        = op_b_reg;
  assign vec_index    = idx_reg;
  assign busy         = busy_reg;
  assign result_valid = valid_reg;
  assign result_hold  = hold_reg;

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// Scoreboard bench for fp_operand_sequencer: a per-edge behavioural model pushes
// expected captures, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_fp_operand_sequencer;

  localparam int DEB = 4;
  localparam int NV  = 8;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        noisy_level = 1'b0;
  logic [31:0] fp_result;
  logic [31:0] reg_A, reg_B, result_hold;
  logic [2:0]  vec_index;
  logic        busy, result_valid;

  always #5 clk = ~clk;

  fp_operand_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_VECTORS    (NV),
    .PIPE_LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .noisy_level (noisy_level),
    .fp_result   (fp_result),
    .reg_A       (reg_A),
    .reg_B       (reg_B),
    .vec_index   (vec_index),
    .busy        (busy),
    .result_valid(result_valid),
    .result_hold (result_hold)
  );

  // Adder stub: reg_A delayed by LAT edges.
  logic [31:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= reg_A;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign fp_result = pipe_q[LAT-1];

  logic [31:0] rom_a [NV] = '{32'h2ac49214, 32'h3f800000, 32'h40400000, 32'h7f800000,
                              32'h3fc00000, 32'h00000000, 32'h7f7fffff, 32'hc0000000};
  logic [31:0] rom_b [NV] = '{32'h6ac49214, 32'h3f800000, 32'hc0400000, 32'h3f800000,
                              32'h3fc00000, 32'h00000000, 32'h7f7fffff, 32'h3f800000};

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_captures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: edge-indexed history of sampled button levels.
  bit samp_q[$];
  bit m_stable;
  int last_rise;
  int free_edge;
  int m_idx;

  function automatic bit samp(input int k);
    if (k < 0 || k >= samp_q.size()) return 1'b0;
    return samp_q[k];
  endfunction

  task automatic model_reset();
    samp_q.delete();
    exp_q.delete();
    m_stable  = 1'b0;
    last_rise = -100;
    free_edge = 0;
    m_idx     = 0;
  endtask

  task automatic model_step();
    int n;
    bit all_diff;
    exp_t e;
    n = samp_q.size();
    // A rise seen at edge n-1 is a press acted on at edge n, if the sequencer is free.
    if (last_rise == n - 1 && n >= free_edge) begin
      m_idx     = (m_idx + 1) % NV;
      e.idx     = m_idx;
      e.a       = rom_a[m_idx];
      e.b       = rom_b[m_idx];
      e.res     = rom_a[m_idx];
      exp_q.push_back(e);
      free_edge = n + LAT + 2;
    end
    // Synchronised level at edge n is the button sampled two edges earlier;
    // the debounced level flips after DEB consecutive differing samples.
    all_diff = 1'b1;
    for (int j = 0; j < DEB; j++)
      if (samp(n - 2 - j) == m_stable) all_diff = 1'b0;
    if (all_diff) begin
      m_stable = ~m_stable;
      if (m_stable) last_rise = n;
    end
    samp_q.push_back(noisy_level);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Monitor
  initial begin
    logic        busy_p, rv_p, brise;
    logic [31:0] hold_p, a_p, b_p;
    int          blen;
    exp_t        e;
    busy_p = 1'b0; rv_p = 1'b0; hold_p = 32'h0; a_p = rom_a[0]; b_p = rom_b[0]; blen = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        busy_p = 1'b0; rv_p = 1'b0; hold_p = 32'h0; a_p = rom_a[0]; b_p = rom_b[0]; blen = 0;
      end else begin
        brise = busy && !busy_p;
        if (busy) blen = brise ? 1 : blen + 1;
        if (!busy && busy_p) check("busy_len", 32'(blen), 32'(LAT + 1));
        if (!brise) begin
          check("opA_stable", reg_A, a_p);
          check("opB_stable", reg_B, b_p);
        end
        if (result_valid && !rv_p) begin
          n_captures++;
          $display("capture %0d: idx=%0d A=%h B=%h result=%h", n_captures, vec_index, reg_A, reg_B, result_hold);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_capture: got capture idx=%0d, required none", vec_index);
          end else begin
            e = exp_q.pop_front();
            check("cap_result", result_hold, e.res);
            check("cap_idx", 32'(vec_index), 32'(e.idx));
            check("cap_A", reg_A, e.a);
            check("cap_B", reg_B, e.b);
          end
        end else begin
          check("hold_stable", result_hold, hold_p);
        end
        busy_p = busy; rv_p = result_valid; hold_p = result_hold; a_p = reg_A; b_p = reg_B;
      end
    end
  end

  task automatic hold_level(input logic v, input int n);
    noisy_level = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_A"},     reg_A, 32'h2ac49214);
    check({tag, "_B"},     reg_B, 32'h6ac49214);
    check({tag, "_idx"},   32'(vec_index), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_hold"},  result_hold, 32'h0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int caps0, t;
    rst = 1'b1;
    noisy_level = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Short pulse, then a held press with a short glitch.
    hold_level(1'b1, 3);
    hold_level(1'b0, 12);
    check("short_idx", 32'(vec_index), 32'd0);
    check("short_caps", 32'(n_captures), 32'd0);
    hold_level(1'b1, 20);
    hold_level(1'b0, 2);
    hold_level(1'b1, 10);
    hold_level(1'b0, 20);
    wait_idle();
    check("press_idx", 32'(vec_index), 32'd1);
    check("press_A", reg_A, 32'h3f800000);
    check("press_B", reg_B, 32'h3f800000);
    check("press_valid", 32'(result_valid), 32'd1);
    check("press_hold", result_hold, 32'h3f800000);
    check("press_caps", 32'(n_captures), 32'd1);

    // Full wrap from index 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    caps0 = n_captures;
    repeat (8) begin
      hold_level(1'b1, 6);
      hold_level(1'b0, LAT + 10);
    end
    wait_idle();
    check("wrap_idx", 32'(vec_index), 32'd0);
    check("wrap_A", reg_A, 32'h2ac49214);
    check("wrap_B", reg_B, 32'h6ac49214);
    check("wrap_hold", result_hold, 32'h2ac49214);
    check("wrap_caps", 32'(n_captures - caps0), 32'd8);

    // Second debounced press lands inside the wait window.
    caps0 = n_captures;
    hold_level(1'b1, DEB);
    hold_level(1'b0, DEB);
    hold_level(1'b1, DEB);
    hold_level(1'b0, 40);
    wait_idle();
    check("drop_idx", 32'(vec_index), 32'd1);
    check("drop_A", reg_A, 32'h3f800000);
    check("drop_caps", 32'(n_captures - caps0), 32'd1);

    // Asynchronous reset in the middle of the wait.
    caps0 = n_captures;
    hold_level(1'b1, 5);
    noisy_level = 1'b0;
    t = 0;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("abort_busy_seen", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("abort");
    #7 rst = 1'b0;
    repeat (LAT + 6) @(negedge clk);
    check("abort_valid_after", 32'(result_valid), 32'd0);
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_caps", 32'(n_captures - caps0), 32'd0);

    // Random button activity.
    repeat (80) hold_level(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    hold_level(1'b0, 40);
    wait_idle();
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule
